hyper_target: RTL
=================

HYPER_TARGET -- requirements
Module: hyper_target

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning 16-bit words of backing memory (power of 2).
REQ-002 SHALL have parameter LATENCY, default 6, meaning initial access latency in clock cycles (1x).
REQ-003 SHALL have parameter CR0_RESET, default 16'h8F1F, meaning configuration register 0 reset value.
REQ-004 clk_i  input  1  sole clock; one clock cycle carries one DDR word (two bus edges).
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 cs_ni  input  1  chip select, active low.
REQ-007 dq_i  input  16  host word per cycle; [15:8] = rising-edge byte, [7:0] = falling-edge byte.
REQ-008 rwds_i  input  2  host write mask per byte lane; 1 = byte masked.
REQ-009 dq_o  output  16  read data word.
REQ-010 dq_oe_o  output  1  dq_o drive enable.
REQ-011 rwds_o  output  2  target strobe/latency indication.
REQ-012 rwds_oe_o  output  1  rwds_o drive enable.

Function
REQ-013 SHALL implement FSM states IDLE, CA, LAT, WDATA, RDATA, REGWR, DONE.
REQ-014 IDLE->CA on first cycle with cs_ni low (cycle 0); CA words captured in cycles 0,1,2 as CA[47:32], CA[31:16], CA[15:0].
REQ-015 CA[47]=1 read / 0 write; CA[46]=1 register space; CA[45]=1 linear burst; word address = {CA[31:16],CA[2:0]} modulo DEPTH_WORDS.
REQ-016 During cycles 0-2, rwds_oe_o=1 and rwds_o=2'b11 if 2x latency, 2'b00 if 1x; 2x when CR0[3]=1, else 1x.
REQ-017 Lc = LATENCY (1x) or 2*LATENCY (2x); first data word at cycle 3+Lc.
REQ-018 Memory/register read: dq_o, dq_oe_o=1, rwds_oe_o=1, rwds_o=2'b10 valid from cycle 3+Lc, one word per cycle, address incrementing, until cs_ni high.
REQ-019 Memory write: word sampled each cycle from 3+Lc; byte written only where rwds_i bit is 0; address increments per word.
REQ-020 Register write (CA[47]=0, CA[46]=1): zero latency, data word at cycle 3 -> REGWR, then DONE; rwds_i ignored.
REQ-021 Register address low 12 bits 0x800 = CR0; reads of other register addresses return 16'h0000; writes to them ignored.
REQ-022 Linear burst address past DEPTH_WORDS-1 SHALL wrap to 0.
REQ-023 cs_ni high in any state SHALL return FSM to IDLE next cycle, drop all _oe outputs, and cancel remaining beats; a write word in progress that cycle is discarded.
REQ-024 DONE holds outputs disabled until cs_ni high.
REQ-025 Write sampled in cycle n is visible to a read whose data phase starts at or after cycle n+1.

Reset
REQ-026 rst_i SHALL force IDLE, CR0=CR0_RESET, dq_o=0, dq_oe_o=0, rwds_o=0, rwds_oe_o=0; memory contents not reset.
REQ-027 rst_i mid-transaction overrides cs_ni; no memory write in the reset cycle.

Configuration
REQ-028 Macro HYPER_TARGET_WRAP_EN SHALL enable wrapped bursts: CA[45]=0 wraps within a group sized by CR0[1:0] (00=64, 01=32, 10=8, 11=16 words).
REQ-029 Without HYPER_TARGET_WRAP_EN, CA[45] SHALL be ignored and all bursts linear.

Verification
REQ-030 After reset, register read 0x800 -> 16'h8F1F, rwds_o=2'b11 during CA, data at cycle 3+12.
REQ-031 Register write 0x800 data 16'h8F17, then read -> 16'h8F17, rwds_o=2'b00 during CA, data at cycle 3+6.
REQ-032 16-word write from 0x10 (cafe, affe, ...) then read back -> identical 16 words, one per cycle.
REQ-033 Three writes to last address: rwds_i 2'b01 data 3411, 2'b10 data 1156, 2'b11 data 1111 -> read 16'h3456.
REQ-034 Read burst from DEPTH_WORDS-2 of 4 words -> addresses DEPTH-2, DEPTH-1, 0, 1.
REQ-035 cs_ni raised after 2 of 8 write words -> only 2 words written, FSM IDLE next cycle; with WRAP_EN, CR0[1:0]=11, wrapped read from 0x0E -> 0x0E, 0x0F, 0x00.

Source files
------------

// File: rtl/hyper_target.sv
// HyperBus-style memory target: CA decode, latency count, burst read/write of a word array plus CR0.
// Latency: first data word at cycle 3+Lc, Lc = LATENCY (1x) or 2*LATENCY (2x, CR0[3]); register writes take no latency.
// Backpressure: none; the host paces the burst with cs_ni, and cs_ni high aborts to IDLE on the next cycle.
// Optional feature: define HYPER_TARGET_WRAP_EN to honour wrapped bursts (CA[45]=0, group size from CR0[1:0]).
module hyper_target #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 6,
   parameter logic [15:0] CR0_RESET   = 16'h8F1F
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cs_ni,
   input  logic [15:0] dq_i,
   input  logic [1:0]  rwds_i,
   output logic [15:0] dq_o,
   output logic        dq_oe_o,
   output logic [1:0]  rwds_o,
   output logic        rwds_oe_o
);

   localparam int         AW    = $clog2(DEPTH_WORDS);
   // Latency counter preload: the LAT state lasts Lc cycles, counting down to zero.
   localparam logic [7:0] LC_1X = 8'(LATENCY - 1);
   localparam logic [7:0] LC_2X = 8'(2 * LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE,
      CA,
      LAT,
      WDATA,
      RDATA,
      REGWR,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [15:0] cr0;
   logic [15:0] ca_mid;
   logic        is_read;
   logic        is_reg;
   logic        ca_second;
   logic [7:0]  lat_cnt;
   logic [18:0] addr;
   logic [18:0] addr_nxt;
   logic [18:0] wrap_mask;
   logic [15:0] rd_word;
   logic        reg_hit;
   logic        lat_2x;
   logic        mem_we;

   logic [15:0] mem [DEPTH_WORDS];

`ifdef HYPER_TARGET_WRAP_EN
   logic        is_lin;

   // Address bits allowed to change on increment: all for linear, group bits for wrapped.
   always_comb begin
      wrap_mask = '1;
      if (!is_lin) begin
         case (cr0[1:0])
            2'b00:   wrap_mask = 19'd63;
            2'b01:   wrap_mask = 19'd31;
            2'b10:   wrap_mask = 19'd7;
            default: wrap_mask = 19'd15;
         endcase
      end
   end
`else
   // Every burst is linear; CA[45] has no effect.
   assign wrap_mask = '1;
`endif

   // Linear increment wraps naturally at DEPTH_WORDS because only the low AW bits index memory.
   assign addr_nxt = (addr & ~wrap_mask) | ((addr + 19'd1) & wrap_mask);
   assign lat_2x   = cr0[3];
   assign reg_hit  = (addr[11:0] == 12'h800);
   assign mem_we   = (state == WDATA) && !cs_ni && !rst_i;
   assign rd_word  = is_reg ? (reg_hit ? cr0 : 16'h0000) : mem[addr[AW-1:0]];

   // State register; reset wins over any cs_ni activity.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and bus drive; outputs are dropped whenever cs_ni is high or reset is active.
   always_comb begin
      state_nxt = state;
      dq_o      = 16'h0000;
      dq_oe_o   = 1'b0;
      rwds_o    = 2'b00;
      rwds_oe_o = 1'b0;

      case (state)
         IDLE: begin
            if (!cs_ni) begin
               state_nxt = CA;
            end
         end
         CA: begin
            if (cs_ni) begin
               state_nxt = IDLE;
            end else if (ca_second) begin
               state_nxt = (is_reg && !is_read) ? REGWR : LAT;
            end
         end
         LAT: begin
            if (cs_ni) begin
               state_nxt = IDLE;
            end else if (lat_cnt == 8'd0) begin
               state_nxt = is_read ? RDATA : WDATA;
            end
         end
         REGWR: begin
            state_nxt = cs_ni ? IDLE : DONE;
         end
         WDATA, RDATA, DONE: begin
            if (cs_ni) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (!rst_i && !cs_ni) begin
         case (state)
            IDLE, CA: begin
               rwds_oe_o = 1'b1;
               rwds_o    = {2{lat_2x}};
            end
            RDATA: begin
               dq_oe_o   = 1'b1;
               dq_o      = rd_word;
               rwds_oe_o = 1'b1;
               rwds_o    = 2'b10;
            end
            default: begin
               rwds_oe_o = 1'b0;
            end
         endcase
      end
   end

   // Command capture, latency countdown, burst address and CR0 update.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cr0       <= CR0_RESET;
         ca_mid    <= 16'h0000;
         is_read   <= 1'b0;
         is_reg    <= 1'b0;
         ca_second <= 1'b0;
         lat_cnt   <= 8'd0;
         addr      <= 19'd0;
`ifdef HYPER_TARGET_WRAP_EN
         is_lin    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               ca_second <= 1'b0;
               if (!cs_ni) begin
                  is_read <= dq_i[15];
                  is_reg  <= dq_i[14];
`ifdef HYPER_TARGET_WRAP_EN
                  is_lin  <= dq_i[13];
`endif
               end
            end
            CA: begin
               if (!cs_ni) begin
                  if (!ca_second) begin
                     ca_mid    <= dq_i;
                     ca_second <= 1'b1;
                  end else begin
                     addr      <= {ca_mid, dq_i[2:0]};
                     lat_cnt   <= lat_2x ? LC_2X : LC_1X;
                     ca_second <= 1'b0;
                  end
               end
            end
            LAT: begin
               if (lat_cnt != 8'd0) begin
                  lat_cnt <= lat_cnt - 8'd1;
               end
            end
            WDATA, RDATA: begin
               if (!cs_ni) begin
                  addr <= addr_nxt;
               end
            end
            REGWR: begin
               // Only CR0 is writable; the host write mask is not applied to registers.
               if (!cs_ni && reg_hit) begin
                  cr0 <= dq_i;
               end
            end
            default: begin
               ca_second <= 1'b0;
            end
         endcase
      end
   end

   // Backing memory with per-byte write mask (rwds_i bit set = lane masked); contents survive reset.
   always_ff @(posedge clk_i) begin
      if (mem_we && !rwds_i[1]) begin
         mem[addr[AW-1:0]][15:8] <= dq_i[15:8];
      end
      if (mem_we && !rwds_i[0]) begin
         mem[addr[AW-1:0]][7:0] <= dq_i[7:0];
      end
   end

endmodule
